// File: rtl/dmem_write_buffer.sv
// -----------------------------------------------------------------------------
// dmem_write_buffer
//
// Posted-store buffer between the processor data-memory port and the data RAM.
// Stores are queued in a small circular FIFO and drained in acceptance order,
// one entry per valid/ready handshake, to the RAM write port. Loads are served
// combinationally: the youngest buffered store to the same word wins, otherwise
// the RAM read data is passed through.
//
// Ports
//   clk             single clock, all state on posedge
//   reset           synchronous, active-low (0 = reset)
//   WE              processor store request
//   address_to_mem  processor byte address (load or store)
//   data_to_mem     processor store data
//   data_from_mem   load data to the processor (combinational)
//   stall           store refused this cycle because the buffer is full
//   mem_rd_addr     RAM read address (mirrors address_to_mem)
//   mem_rd_data     RAM read data (combinational from mem_rd_addr)
//   mem_wr_valid    head entry presented to the RAM
//   mem_wr_ready    RAM accepts the head entry
//   mem_wr_addr     head entry word address, byte bits forced to zero
//   mem_wr_data     head entry data
//   empty           no stores pending
//   full            DEPTH stores pending
// -----------------------------------------------------------------------------
module dmem_write_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          WE,
   input  logic [AW-1:0] address_to_mem,
   input  logic [31:0]   data_to_mem,
   output logic [31:0]   data_from_mem,
   output logic          stall,
   output logic [AW-1:0] mem_rd_addr,
   input  logic [31:0]   mem_rd_data,
   output logic          mem_wr_valid,
   input  logic          mem_wr_ready,
   output logic [AW-1:0] mem_wr_addr,
   output logic [31:0]   mem_wr_data,
   output logic          empty,
   output logic          full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // Entry storage: word address and data. Not reset; contents only matter
   // while covered by count.
   logic [AW-3:0] ent_addr [DEPTH];
   logic [31:0]   ent_data [DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic push;
   logic pop;
   logic fwd_hit;
   logic [31:0] fwd_data;

   assign full         = (count == CW'(DEPTH));
   assign empty        = (count == '0);
   assign push         = WE & ~full;
   // No bypass against a same-cycle pop: the store retries next cycle.
   assign stall        = WE & full;
   assign mem_wr_valid = ~empty;
   assign pop          = mem_wr_valid & mem_wr_ready;

   assign mem_wr_addr  = {ent_addr[rd_ptr], 2'b00};
   assign mem_wr_data  = ent_data[rd_ptr];
   assign mem_rd_addr  = address_to_mem;

   // Walk the valid entries oldest to youngest so the last match seen is the
   // youngest. Uses pre-edge state, so an entry draining this cycle still hits.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CW'(i) < count) &&
             (ent_addr[PW'(rd_ptr + PW'(i))] == address_to_mem[AW-1:2])) begin
            fwd_hit  = 1'b1;
            fwd_data = ent_data[PW'(rd_ptr + PW'(i))];
         end
      end
   end

   assign data_from_mem = fwd_hit ? fwd_data : mem_rd_data;

   // Control state: pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Data path: entry write on accepted store.
   always_ff @(posedge clk) begin
      if (push) begin
         ent_addr[wr_ptr] <= address_to_mem[AW-1:2];
         ent_data[wr_ptr] <= data_to_mem;
      end
   end

endmodule

// File: doc/dmem_write_buffer.md
Name: dmem_write_buffer

Overview:
- Responder for the processor's data-memory interface (WE, address_to_mem, data_to_mem, data_from_mem).
- Posts stores into a small FIFO and drains them one per handshake to a backing data RAM over a valid/ready write port.
- Serves loads combinationally, forwarding from the youngest matching buffered store, otherwise from the backing RAM read port.
- Sits between the processor core and the data RAM. Adds a stall output for the core's PC-hold logic.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- AW, 32, byte-address width on both sides.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on posedge clk.
- WE  input  1  processor store request this cycle.
- address_to_mem  input  AW  processor byte address for load or store.
- data_to_mem  input  32  processor store data.
- data_from_mem  output  32  load data returned to the processor, combinational.
- stall  output  1  store could not be accepted; processor must hold the instruction.
- mem_rd_addr  output  AW  backing RAM read address; equals address_to_mem.
- mem_rd_data  input  32  backing RAM read data, combinational from mem_rd_addr.
- mem_wr_valid  output  1  head entry presented to backing RAM.
- mem_wr_ready  input  1  backing RAM accepts the head entry this cycle.
- mem_wr_addr  output  AW  head entry address, with bits [1:0] forced to 0.
- mem_wr_data  output  32  head entry data.
- empty  output  1  no stores pending; used by the core for fence/halt.
- full  output  1  count == DEPTH.

Behaviour:
- Storage: circular FIFO of DEPTH entries, each holding {word address = addr[AW-1:2], data}.
  - wr_ptr and rd_ptr are log2(DEPTH) bits wide and wrap naturally.
  - count is log2(DEPTH)+1 bits wide.
- Reset (reset==0 at posedge): wr_ptr=0, rd_ptr=0, count=0.
  - All pending stores are discarded, including a reset mid-drain.
  - Resulting outputs: empty=1, full=0, mem_wr_valid=0.
  - stall=0 unless WE is high while the buffer is full. After reset it is never full, so stall=0.
  - Entry contents are don't-care.
- Push: push = WE & !full. On posedge, the entry is written at wr_ptr and wr_ptr increments.
- Stall: stall = WE & full, purely combinational. No same-cycle bypass: a stall is raised even if a pop happens that same cycle. The store is accepted in a later cycle.
- Pop: pop = mem_wr_valid & mem_wr_ready, where mem_wr_valid = !empty.
  - mem_wr_addr/mem_wr_data show the entry at rd_ptr.
  - They must stay stable while valid=1 and ready=0.
  - On posedge with pop, rd_ptr increments.
- Count: count += push - pop.
  - Simultaneous push and pop leaves count unchanged.
  - Push and pop on an empty buffer is impossible, because pop requires !empty.
- Ordering: stores drain strictly in acceptance order. Same-address stores are never merged.
- Load forwarding:
  - Compare address_to_mem[AW-1:2] against every valid entry.
  - data_from_mem = data of the youngest valid match; if there is no match, data_from_mem = mem_rd_data.
  - The comparison uses register state before the current-cycle push or pop. An entry popping this cycle still forwards.
- Latency:
  - A store becomes visible to loads in the cycle after acceptance.
  - With ready held at 1, a store reaches backing RAM at the earliest posedge after acceptance, i.e. the second posedge counting the accepting one.
- Partial stores are not supported; every store is a full word.
- Byte-address bits [1:0] are ignored for both match and drain.

Test Plan:
1. Reset and drain:
   - Hold reset=0 for 2 cycles with WE=1 → stall=0, empty=1, mem_wr_valid=0.
   - Release reset, write 0x10←0xAAAA5555 with mem_wr_ready=1 → mem_wr_valid=1 on the next cycle with addr 0x10 / data 0xAAAA5555; empty=1 one cycle later.
2. Forwarding priority:
   - With mem_wr_ready=0, store 0x20←0x1, then 0x24←0x2, then 0x20←0x3.
   - Load 0x20 → 0x3; load 0x24 → 0x2; load 0x22 → 0x3 (bits [1:0] ignored).
   - Load 0x28 with mem_rd_data=0xDEAD → 0xDEAD.
3. Full and stall:
   - With ready=0, perform 4 stores → full=1.
   - A 5th store (WE=1) → stall=1 and count stays 4.
   - Raise ready for one cycle → head popped, stall stays 1 that cycle; the next cycle the store is accepted and stall=0.
4. Backpressure stability:
   - Toggle ready 0/1/0/1 while 3 entries are pending → mem_wr_addr/data are unchanged whenever ready=0.
   - Drain order matches store order.
5. Simultaneous push and pop: with count=2 and ready=1, store each cycle for 6 cycles → count stays 2 and no stall; pointers wrap past DEPTH without corruption.
6. Reset mid-operation: with 3 entries pending, assert reset=0 for 1 cycle → empty=1 and mem_wr_valid=0; a load of a previously buffered address returns mem_rd_data.
